// File: rtl/pixel_seq_ctrl.sv
// Readout sequencer for an N-channel photodiode array sharing one
// integrator / sample-hold / single-slope comparator chain. Each enabled
// channel runs reset, integrate, sample-hold and conversion; results leave
// on a valid/ready stream.
module pixel_seq_ctrl #(
    parameter int unsigned N_PD = 12,
    parameter int unsigned CW   = 10,
    parameter int unsigned TW   = 8,
    parameter int unsigned CHW  = $clog2(N_PD)
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic            cont_i,
    input  logic [N_PD-1:0] ch_mask_i,
    input  logic [TW-1:0]   t_rst_i,
    input  logic [TW-1:0]   t_int_i,
    input  logic [TW-1:0]   t_sh_i,
    input  logic            cmp_i,
    output logic [N_PD-1:0] pd_a_o,
    output logic [N_PD-1:0] pd_b_o,
    output logic            sh_rst_o,
    output logic            sh_o,
    output logic            sh_cmp_o,
    output logic            counter_rst_o,
    output logic [CW-1:0]   res_data_o,
    output logic [CHW-1:0]  res_ch_o,
    output logic            res_sat_o,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [2:0] {StIdle, StRst, StInt, StSh, StConv, StOut, StNext} state_e;

    localparam logic [CW-1:0]   CntMax  = {CW{1'b1}};
    localparam logic [N_PD-1:0] OneHot0 = N_PD'(1);

    state_e          state_q, state_d;
    logic [N_PD-1:0] mask_q, mask_d;
    logic [TW-1:0]   t_rst_q, t_rst_d, t_int_q, t_int_d, t_sh_q, t_sh_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [CW-1:0]   cnt_q, cnt_d, res_data_q, res_data_d;
    logic            res_sat_q, res_sat_d;
    logic            conv_first_q, conv_first_d;
    logic            stop_q, stop_d, done_q, done_d;
    logic            cmp_meta_q, cmp_s_q;
    logic            frame_end, capture, stop_pend;
    logic [CHW-1:0]  first_ch, next_ch;
    logic            next_found;

    // A programmed length of 0 behaves as 1: last count index is t-1, floored at 0
    function automatic logic [TW-1:0] last_idx(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Lowest set bit of the incoming mask; next set bit above ch_q in the latched mask
    always_comb begin
        first_ch   = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = N_PD - 1; i >= 0; i--) begin
            if (ch_mask_i[i]) first_ch = CHW'(i);
            if (mask_q[i] && (i > int'(ch_q))) begin
                next_ch    = CHW'(i);
                next_found = 1'b1;
            end
        end
    end

    // Sequencer next state, frame capture and conversion counting
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        t_rst_d      = t_rst_q;
        t_int_d      = t_int_q;
        t_sh_d       = t_sh_q;
        tcnt_d       = tcnt_q;
        ch_d         = ch_q;
        cnt_d        = cnt_q;
        conv_first_d = conv_first_q;
        res_data_d   = res_data_q;
        res_sat_d    = res_sat_q;
        done_d       = 1'b0;
        frame_end    = 1'b0;
        capture      = 1'b0;
        stop_pend    = stop_q | stop_i;
        stop_d       = stop_q | (stop_i & (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (ch_mask_i == '0) done_d = 1'b1;
                    else                 capture = 1'b1;
                end
            end
            StRst: begin
                if (tcnt_q >= last_idx(t_rst_q)) begin
                    tcnt_d  = '0;
                    state_d = StInt;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            StInt: begin
                if (tcnt_q >= last_idx(t_int_q)) begin
                    tcnt_d  = '0;
                    state_d = StSh;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            StSh: begin
                if (tcnt_q >= last_idx(t_sh_q)) begin
                    tcnt_d       = '0;
                    cnt_d        = '0;
                    conv_first_d = 1'b1;
                    state_d      = StConv;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            StConv: begin
                // Entry cycle only clears the counter; the ramp starts the cycle after
                if (conv_first_q) begin
                    conv_first_d = 1'b0;
                    cnt_d        = CW'(1);
                end else if (cmp_s_q) begin
                    res_data_d = cnt_q;
                    res_sat_d  = 1'b0;
                    state_d    = StOut;
                end else if (cnt_q == CntMax) begin
                    res_data_d = CntMax;
                    res_sat_d  = 1'b1;
                    state_d    = StOut;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StOut: begin
                if (res_ready_i) state_d = StNext;
            end
            StNext: begin
                if (next_found && !stop_pend) begin
                    ch_d    = next_ch;
                    tcnt_d  = '0;
                    state_d = StRst;
                end else if (cont_i && !stop_pend && (ch_mask_i != '0)) begin
                    capture = 1'b1;
                end else begin
                    frame_end = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Shared by frame start and continuous-mode restart
        if (capture) begin
            mask_d  = ch_mask_i;
            t_rst_d = t_rst_i;
            t_int_d = t_int_i;
            t_sh_d  = t_sh_i;
            ch_d    = first_ch;
            tcnt_d  = '0;
            state_d = StRst;
        end

        if (state_d == StIdle) stop_d = 1'b0;
    end

    // Analog phase controls decoded from the current state
    always_comb begin
        pd_a_o        = '0;
        pd_b_o        = '0;
        sh_rst_o      = 1'b0;
        sh_o          = 1'b0;
        sh_cmp_o      = 1'b0;
        counter_rst_o = 1'b0;
        unique case (state_q)
            StRst: begin
                pd_a_o   = OneHot0 << ch_q;
                sh_rst_o = 1'b1;
            end
            StInt: pd_a_o = OneHot0 << ch_q;
            StSh: begin
                pd_b_o = OneHot0 << ch_q;
                sh_o   = 1'b1;
            end
            StConv: begin
                counter_rst_o = conv_first_q;
                sh_cmp_o      = ~conv_first_q;
            end
            default: ;
        endcase
    end

    assign res_valid_o = (state_q == StOut);
    assign res_data_o  = res_data_q;
    assign res_ch_o    = ch_q;
    assign res_sat_o   = res_sat_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q | frame_end;

    // Two-flop synchroniser for the asynchronous comparator output
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cmp_meta_q <= 1'b0;
            cmp_s_q    <= 1'b0;
        end else begin
            cmp_meta_q <= cmp_i;
            cmp_s_q    <= cmp_meta_q;
        end
    end

    // Sequencer state registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            t_rst_q      <= '0;
            t_int_q      <= '0;
            t_sh_q       <= '0;
            tcnt_q       <= '0;
            ch_q         <= '0;
            cnt_q        <= '0;
            conv_first_q <= 1'b0;
            res_data_q   <= '0;
            res_sat_q    <= 1'b0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            t_rst_q      <= t_rst_d;
            t_int_q      <= t_int_d;
            t_sh_q       <= t_sh_d;
            tcnt_q       <= tcnt_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            conv_first_q <= conv_first_d;
            res_data_q   <= res_data_d;
            res_sat_q    <= res_sat_d;
            stop_q       <= stop_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Bench for pixel_seq_ctrl: a 12-channel CW=10 instance (A) for timing, mask,
// back-pressure and reset cases, and a 3-channel CW=4 instance (B) for
// saturation and continuous mode with stop. Results are checked against a
// scoreboard of expected {data, ch, sat} records.
module tb_pixel_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, stop, cont, cmp, ready;
    logic [7:0]  t_rst, t_int, t_sh;
    logic [11:0] mask_a;
    logic [2:0]  mask_b;

    logic [11:0] pd_a_a, pd_b_a;
    logic        sh_rst_a, sh_a, sh_cmp_a, crst_a, sat_a, valid_a, busy_a, done_a;
    logic [9:0]  data_a;
    logic [3:0]  ch_a;

    logic [2:0]  pd_a_b, pd_b_b;
    logic        sh_rst_b, sh_b, sh_cmp_b, crst_b, sat_b, valid_b, busy_b, done_b;
    logic [3:0]  data_b;
    logic [1:0]  ch_b;

    pixel_seq_ctrl #(.N_PD(12), .CW(10), .TW(8)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .stop_i(stop), .cont_i(cont),
        .ch_mask_i(mask_a), .t_rst_i(t_rst), .t_int_i(t_int), .t_sh_i(t_sh), .cmp_i(cmp),
        .pd_a_o(pd_a_a), .pd_b_o(pd_b_a), .sh_rst_o(sh_rst_a), .sh_o(sh_a),
        .sh_cmp_o(sh_cmp_a), .counter_rst_o(crst_a), .res_data_o(data_a), .res_ch_o(ch_a),
        .res_sat_o(sat_a), .res_valid_o(valid_a), .res_ready_i(ready), .busy_o(busy_a),
        .done_o(done_a)
    );

    pixel_seq_ctrl #(.N_PD(3), .CW(4), .TW(8)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .stop_i(stop), .cont_i(cont),
        .ch_mask_i(mask_b), .t_rst_i(t_rst), .t_int_i(t_int), .t_sh_i(t_sh), .cmp_i(cmp),
        .pd_a_o(pd_a_b), .pd_b_o(pd_b_b), .sh_rst_o(sh_rst_b), .sh_o(sh_b),
        .sh_cmp_o(sh_cmp_b), .counter_rst_o(crst_b), .res_data_o(data_b), .res_ch_o(ch_b),
        .res_sat_o(sat_b), .res_valid_o(valid_b), .res_ready_i(ready), .busy_o(busy_b),
        .done_o(done_b)
    );

    typedef struct packed {
        logic [9:0] data;
        logic [3:0] ch;
        logic       sat;
    } res_t;

    typedef struct {
        logic [11:0] mask;
        logic [7:0]  tr, ti, ts;
        int          k;
        bit          stall;
    } vec_t;

    res_t q_a[$], q_b[$];
    res_t exp_r;
    int   n_vec = 0, n_err = 0;
    int   done_cnt_a = 0, done_cnt_b = 0, xfer_cnt_b = 0;
    int   cmp_k = 7, exp_pda_len = 7, exp_pdb_len = 3;
    int   run_a = 0, run_b = 0, stall_cnt = 0;
    bit   cmp_en = 1'b0, stall_en = 1'b0;
    bit   stall_prev_a = 1'b0, prev_xfer_a = 1'b0, prev_xfer_b = 1'b0;
    logic [14:0] snap_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int max1(input logic [7:0] t);
        return (t == 8'd0) ? 1 : int'(t);
    endfunction

    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done_a(input int target, input int budget);
        int n = 0;
        while (done_cnt_a < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_a_reached", 32'(done_cnt_a >= target), 32'd1);
    endtask

    task automatic wait_done_b(input int target, input int budget);
        int n = 0;
        while (done_cnt_b < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_b_reached", 32'(done_cnt_b >= target), 32'd1);
    endtask

    // Comparator model: ramp crosses cmp_k cycles after the counter clear strobe
    initial begin : cmp_model
        cmp = 1'b0;
        forever begin
            @(negedge clk);
            if (cmp_en && (crst_a || crst_b)) begin
                repeat (cmp_k - 2) @(posedge clk);
                #1 cmp = 1'b1;
                @(posedge clk);
                #1 cmp = 1'b0;
            end
        end
    end

    // Downstream sink, phase-length and stall monitor, scoreboard pops
    initial begin : monitor
        ready = 1'b1;
        forever begin
            @(negedge clk);
            if (done_a) done_cnt_a++;
            if (done_b) done_cnt_b++;

            if (!stall_en) begin
                ready = 1'b1;
            end else if (valid_a || valid_b) begin
                if (stall_cnt >= 20) ready = 1'b1;
                else begin
                    stall_cnt++;
                    ready = 1'b0;
                end
            end else begin
                stall_cnt = 0;
                ready     = 1'b0;
            end

            if (pd_a_a != '0 || pd_b_a != '0)
                check("pd_onehot_excl", 32'($onehot0(pd_a_a) && $onehot0(pd_b_a) &&
                      !(pd_a_a != '0 && pd_b_a != '0)), 32'd1);
            if (pd_a_a != '0) run_a++;
            else if (run_a != 0) begin
                check("pd_a_len", 32'(run_a), 32'(exp_pda_len));
                run_a = 0;
            end
            if (pd_b_a != '0) run_b++;
            else if (run_b != 0) begin
                check("pd_b_len", 32'(run_b), 32'(exp_pdb_len));
                run_b = 0;
            end

            if (prev_xfer_a) check("valid_a_drop", 32'(valid_a), 32'd0);
            if (stall_prev_a && valid_a) begin
                check("stall_data", 32'({data_a, ch_a, sat_a}), 32'(snap_a));
                check("stall_quiet", 32'({pd_a_a, pd_b_a, sh_rst_a, sh_a, sh_cmp_a, crst_a}),
                      32'd0);
            end
            prev_xfer_a  = valid_a && ready;
            stall_prev_a = valid_a && !ready;
            snap_a       = {data_a, ch_a, sat_a};
            if (valid_a && ready) begin
                check("res_a_pending", 32'(q_a.size() != 0), 32'd1);
                if (q_a.size() != 0) begin
                    exp_r = q_a.pop_front();
                    check("res_a", 32'({data_a, ch_a, sat_a}), 32'(exp_r));
                end
            end

            if (prev_xfer_b) check("valid_b_drop", 32'(valid_b), 32'd0);
            prev_xfer_b = valid_b && ready;
            if (valid_b && ready) begin
                xfer_cnt_b++;
                check("res_b_pending", 32'(q_b.size() != 0), 32'd1);
                if (q_b.size() != 0) begin
                    exp_r = q_b.pop_front();
                    check("res_b", 32'({6'd0, data_b, 2'd0, ch_b, sat_b}), 32'(exp_r));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t        tbl [4];
        res_t        r;
        int          d0, x0, n;
        logic [11:0] m, lowbit;

        tbl[0] = '{mask: 12'hFFF, tr: 8'd2, ti: 8'd5, ts: 8'd3, k: 7, stall: 1'b0};
        tbl[1] = '{mask: 12'h811, tr: 8'd2, ti: 8'd5, ts: 8'd3, k: 7, stall: 1'b1};
        tbl[2] = '{mask: 12'h001, tr: 8'd0, ti: 8'd0, ts: 8'd0, k: 7, stall: 1'b0};
        tbl[3] = '{mask: 12'h0A0, tr: 8'd1, ti: 8'd3, ts: 8'd2, k: 4, stall: 1'b0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
        t_rst = 8'd2; t_int = 8'd5; t_sh = 8'd3;
        mask_a = '0; mask_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl_a", 32'({pd_a_a, pd_b_a, sh_rst_a, sh_a, sh_cmp_a, crst_a,
              valid_a, busy_a, done_a}), 32'd0);
        check("reset_res_a", 32'({data_a, ch_a, sat_a}), 32'd0);
        check("reset_b", 32'({pd_a_b, pd_b_b, sh_rst_b, sh_b, sh_cmp_b, crst_b, valid_b,
              busy_b, done_b, data_b, ch_b, sat_b}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table-driven frames on instance A
        for (int v = 0; v < 4; v++) begin
            m = tbl[v].mask;
            mask_a = m; t_rst = tbl[v].tr; t_int = tbl[v].ti; t_sh = tbl[v].ts;
            cmp_k = tbl[v].k; cmp_en = 1'b1; stall_en = tbl[v].stall;
            exp_pda_len = max1(tbl[v].tr) + max1(tbl[v].ti);
            exp_pdb_len = max1(tbl[v].ts);
            for (int c = 0; c < 12; c++) begin
                if (m[c]) begin
                    r.data = 10'(tbl[v].k); r.ch = 4'(c); r.sat = 1'b0;
                    q_a.push_back(r);
                end
            end
            lowbit = m & (~m + 12'd1);
            d0 = done_cnt_a;
            start_pulse();
            @(negedge clk);
            check("first_rst_cycle", 32'({busy_a, pd_a_a, sh_rst_a}), 32'({1'b1, lowbit, 1'b1}));
            wait_done_a(d0 + 1, 5000);
            repeat (5) @(posedge clk);
            check("done_a_once", 32'(done_cnt_a - d0), 32'd1);
            check("q_a_drained", 32'(q_a.size()), 32'd0);
            check("busy_a_end", 32'(busy_a), 32'd0);
        end
        stall_en = 1'b0;

        // Zero mask: done on the next cycle, never busy
        mask_a = '0;
        start_pulse();
        @(negedge clk);
        check("zero_mask_done", 32'({done_a, busy_a}), 32'b10);
        @(negedge clk);
        check("zero_mask_after", 32'({done_a, busy_a}), 32'b00);

        // Saturation on B (CW=4, comparator never fires)
        t_rst = 8'd2; t_int = 8'd5; t_sh = 8'd3;
        cmp_en = 1'b0; mask_b = 3'b010;
        r.data = 10'd15; r.ch = 4'd1; r.sat = 1'b1;
        q_b.push_back(r);
        d0 = done_cnt_b;
        start_pulse();
        wait_done_b(d0 + 1, 2000);
        repeat (3) @(posedge clk);
        check("q_b_sat_drained", 32'(q_b.size()), 32'd0);

        // Continuous mode on B, stop mid-INT of channel 0 in the third frame
        cont = 1'b1; cmp_en = 1'b1; cmp_k = 3; mask_b = 3'b101;
        for (int i = 0; i < 5; i++) begin
            r.data = 10'd3; r.ch = (i % 2 == 0) ? 4'd0 : 4'd2; r.sat = 1'b0;
            q_b.push_back(r);
        end
        d0 = done_cnt_b;
        x0 = xfer_cnt_b;
        start_pulse();
        n = 0;
        while (xfer_cnt_b < x0 + 4 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("cont_progress", 32'(xfer_cnt_b - x0 >= 4), 32'd1);
        n = 0;
        while (!pd_a_b[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cont_ch0_restart", 32'(pd_a_b[0]), 32'd1);
        check("cont_no_done", 32'(done_cnt_b - d0), 32'd0);
        repeat (3) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        wait_done_b(d0 + 1, 2000);
        repeat (10) @(posedge clk);
        check("cont_stop_q_b", 32'(q_b.size()), 32'd0);
        check("cont_stop_idle", 32'({busy_b, valid_b}), 32'd0);
        check("cont_stop_done", 32'(done_cnt_b - d0), 32'd1);
        cont = 1'b0; mask_b = '0;

        // Asynchronous reset in the middle of a conversion
        cmp_en = 1'b0; mask_a = 12'h002;
        exp_pda_len = 7; exp_pdb_len = 3;
        start_pulse();
        n = 0;
        while (!sh_cmp_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_conv", 32'(sh_cmp_a), 32'd1);
        d0 = done_cnt_a;
        #2 rst = 1'b1;
        #1;
        check("async_rst_ctrl", 32'({pd_a_a, pd_b_a, sh_rst_a, sh_a, sh_cmp_a, crst_a,
              valid_a, busy_a, done_a}), 32'd0);
        check("async_rst_res", 32'({data_a, ch_a, sat_a}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        check("rst_no_done", 32'(done_cnt_a - d0), 32'd0);

        // Normal frame after reset, with a second start while busy
        cmp_en = 1'b1; cmp_k = 5; mask_a = 12'h003;
        for (int c = 0; c < 2; c++) begin
            r.data = 10'd5; r.ch = 4'(c); r.sat = 1'b0;
            q_a.push_back(r);
        end
        d0 = done_cnt_a;
        start_pulse();
        repeat (4) @(posedge clk);
        #1 start = 1'b1; mask_a = 12'hFFF; t_int = 8'd9;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done_a(d0 + 1, 2000);
        repeat (5) @(posedge clk);
        check("busy_start_done", 32'(done_cnt_a - d0), 32'd1);
        check("busy_start_q", 32'(q_a.size()), 32'd0);
        check("busy_start_idle", 32'(busy_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_seq_ctrl.md
Name: pixel_seq_ctrl

Overview:
- Parametrised readout sequencer for an N-channel photodiode pixel array and its shared integrator / S/H / comparator chain.
- Per enabled channel it runs four phases in order: reset, integrate, sample-hold and single-slope conversion.
- Each conversion result goes out on a valid/ready stream.
- It generalises the fixed 12-photodiode control path with: variable channel count, runtime phase timing, a channel mask, continuous mode, graceful stop and saturation flagging.

Parameters:
- N_PD, 12, number of photodiode channels (2..32).
- CW, 10, conversion counter / result width.
- TW, 8, width of the phase-duration inputs.
- CHW, $clog2(N_PD), channel index width.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  frame start pulse.
- stop_i  in  1  request stop after the current channel.
- cont_i  in  1  continuous mode: loop frames.
- ch_mask_i  in  N_PD  channel enable mask.
- t_rst_i, t_int_i, t_sh_i  in  TW each  phase lengths in cycles.
- cmp_i  in  1  comparator output (asynchronous, from the analog block).
- pd_a_o  out  N_PD  one-hot: photodiode-to-integrator switch.
- pd_b_o  out  N_PD  one-hot: photodiode-to-S/H switch.
- sh_rst_o, sh_o, sh_cmp_o  out  1 each  analog phase controls.
- counter_rst_o  out  1  conversion counter clear strobe.
- res_data_o  out  CW  conversion result.
- res_ch_o  out  CHW  channel of the result.
- res_sat_o  out  1  result saturated.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  downstream ready.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset: asynchronous, active-high on wb_rst_i, effective immediately.
  - All outputs go to 0. State goes to IDLE; counters, stop latch and cmp synchroniser clear.
  - Reset mid-frame aborts the frame with no done_o.
- cmp_i passes through a 2-flop synchroniser (cmp_s) before use.
- Frame capture: start_i in IDLE latches ch_mask_i, t_rst_i, t_int_i and t_sh_i, and selects the lowest set mask bit.
  - start_i while busy_o=1 is ignored.
  - If the latched mask is 0: done_o pulses on the next cycle and the block stays IDLE; busy_o never rises.
- States: IDLE -> RST -> INT -> SH -> CONV -> OUT -> NEXT.
  - First RST cycle is the cycle after start_i.
  - A phase length of 0 is treated as 1.
- RST, for t_rst cycles:
  - pd_a_o[ch] and sh_rst_o high.
- INT, for t_int cycles:
  - pd_a_o[ch] high.
- SH, for t_sh cycles:
  - pd_b_o[ch] and sh_o high.
- CONV:
  - Entry cycle: counter_rst_o high and count=0.
  - Following cycles: sh_cmp_o high and count increments by 1 per cycle.
  - Exit on the first cycle cmp_s=1: result=count, sat=0.
  - Exit if count reaches 2^CW-1 first: result=2^CW-1, sat=1.
  - If cmp_s=1 and count=max occur together, sat=0.
- OUT:
  - res_valid_o high, with res_data_o, res_ch_o and res_sat_o held stable until res_ready_i=1.
  - Transfer occurs on the cycle valid and ready are both high; valid drops on the next cycle.
  - The sequencer stalls indefinitely; all analog controls stay low while stalled.
- NEXT (1 cycle): selects the next higher set bit of the latched mask.
  - If a next bit exists and no stop is pending: go to RST.
  - If none remain, cont_i=1 and no stop is pending: restart at the lowest set bit, re-latch timing and mask, go to RST. No done_o between frames.
  - Otherwise: pulse done_o, go to IDLE.
- stop_i: sampled any cycle while busy and held in a sticky latch.
  - The current channel completes through OUT, then the block ends via NEXT with done_o.
  - The latch clears on entry to IDLE.
- Output exclusivity: pd_a_o and pd_b_o are never both non-zero. At most one bit of each is set.
- busy_o is high from the first RST cycle through the NEXT cycle that returns to IDLE.

Test Plan:
- Full-mask timing: N_PD=12, mask=12'hFFF, t_rst=2, t_int=5, t_sh=3, cmp_s rises 7 cycles into CONV, ready tied 1.
  - Expect 12 results with ch 0..11 and data=7, sat=0.
  - Each channel shows pd_a_o high 7 cycles then pd_b_o high 3 cycles.
  - Exactly one done_o.
- Saturation: CW=4, cmp_i held 0.
  - Expect res_data_o=15 and res_sat_o=1.
- Sparse mask with back-pressure: mask=12'h811, ready low for 20 cycles in each OUT.
  - Expect results ordered ch 0, 4, 11 in that order.
  - Data stays stable while stalled; no analog control toggles during the stall.
- Zero mask and phase-0 timing: mask=0 -> done_o on the cycle after start, busy_o stays 0.
  - mask=1 with all t=0 -> each phase lasts 1 cycle.
- Continuous mode with stop: cont_i=1, mask=3'b101 (N_PD=3).
  - Frames loop ch 0, 2, 0, 2 with no done_o between frames.
  - stop_i pulsed mid-INT of ch 0 -> ch 0 result delivered, then done_o, then IDLE; ch 2 not run.
- Async reset and start-while-busy: wb_rst_i asserted mid-CONV -> all outputs 0 immediately, no done_o, next start_i runs normally.
  - start_i pulsed while busy -> no effect on the sequence.
